// File: rtl/nvdla_rubik_wcmd_ram_256x11_pkg.sv
// Shared geometry of the RUBIK write-command RAM.
package nvdla_rubik_wcmd_ram_256x11_pkg;

  localparam int unsigned RAM_DEPTH = 256;
  localparam int unsigned RAM_AW    = 8;
  localparam int unsigned RAM_DW    = 11;
  localparam int unsigned PWRBUS_W  = 32;

endpackage

// File: rtl/nv_clk_gate_power_cell.sv
// Latch-based integrated clock gate; enable is forced on while reset is asserted.
module nv_clk_gate_power_cell (
  input  logic clk,
  input  logic reset_,
  input  logic clk_en,
  output logic clk_gated
);

  logic en_lat;

  // Transparent while clk is low so the enable is stable across the high phase.
  always_latch begin
    if (!reset_) begin
      en_lat <= 1'b1;
    end else if (!clk) begin
      en_lat <= clk_en;
    end
  end

  assign clk_gated = clk & en_lat;

endmodule

// File: rtl/nvdla_rubik_wcmd_ram_256x11.sv
// 256x11 two-port RAM: synchronous write, two-stage (re/ore) pipelined read on a gated clock.
module nvdla_rubik_wcmd_ram_256x11
  import nvdla_rubik_wcmd_ram_256x11_pkg::*;
#(
  parameter bit FORCE_CONTENTION_ASSERTION_RESET_ACTIVE = 1'b0
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  input  logic [PWRBUS_W-1:0] pwrbus_ram_pd,
  input  logic [RAM_AW-1:0]   wa,
  input  logic                we,
  input  logic [RAM_DW-1:0]   di,
  input  logic [RAM_AW-1:0]   ra,
  input  logic                re,
  input  logic                ore,
  output logic [RAM_DW-1:0]   dout
);

  logic              ram_clk;
  logic              ram_clk_en;
  logic [RAM_DW-1:0] mem [RAM_DEPTH];
  logic [RAM_DW-1:0] rd_data;
  logic              unused_pwrbus;

  // Power controls only matter to the physical macro.
  assign unused_pwrbus = ^pwrbus_ram_pd;

  assign ram_clk_en = we | re | ore;

  nv_clk_gate_power_cell u_clk_gate (
    .clk       (nvdla_core_clk),
    .reset_    (nvdla_core_rstn),
    .clk_en    (ram_clk_en),
    .clk_gated (ram_clk)
  );

  // Array is never reset; contents survive a reset pulse.
  always_ff @(posedge ram_clk) begin
    if (we && nvdla_core_rstn) begin
      mem[wa] <= di;
    end
  end

  always_ff @(posedge ram_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      rd_data <= '0;
    end else if (re) begin
      rd_data <= mem[ra];
    end
  end

  always_ff @(posedge ram_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      dout <= '0;
    end else if (ore) begin
      dout <= rd_data;
    end
  end

  // Same-address read/write returns stale data; flag it unless the check is held in reset.
  contention_chk : assert property (
    @(posedge ram_clk) disable iff (!nvdla_core_rstn || FORCE_CONTENTION_ASSERTION_RESET_ACTIVE)
    !(we && re && (wa == ra))
  );

endmodule

// File: tb/tb_nvdla_rubik_wcmd_ram_256x11.sv
// Directed self-checking bench for the RUBIK write-command RAM.
module tb_nvdla_rubik_wcmd_ram_256x11;

  logic        nvdla_core_clk;
  logic        nvdla_core_rstn;
  logic [31:0] pwrbus_ram_pd;
  logic [7:0]  wa;
  logic        we;
  logic [10:0] di;
  logic [7:0]  ra;
  logic        re;
  logic        ore;
  logic [10:0] dout;

  int total;
  int bad;
  int gcnt;

  nvdla_rubik_wcmd_ram_256x11 #(
    .FORCE_CONTENTION_ASSERTION_RESET_ACTIVE(1'b1)
  ) dut (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .pwrbus_ram_pd   (pwrbus_ram_pd),
    .wa              (wa),
    .we              (we),
    .di              (di),
    .ra              (ra),
    .re              (re),
    .ore             (ore),
    .dout            (dout)
  );

  initial nvdla_core_clk = 1'b0;
  always #5 nvdla_core_clk = ~nvdla_core_clk;

  always @(posedge dut.ram_clk) gcnt++;

  task automatic step();
    @(posedge nvdla_core_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    we = 1'b0; re = 1'b0; ore = 1'b0;
    wa = '0; ra = '0; di = '0;
  endtask

  task automatic stream(input logic [31:0] pwr);
    pwrbus_ram_pd = pwr;
    for (int i = 0; i < 256; i++) begin
      we = 1'b1; wa = i[7:0]; di = 11'(i);
      step();
    end
    we = 1'b0;
    // Read 0..255 then wrap to 0; dout lags the issued address by one edge.
    for (int k = 0; k < 258; k++) begin
      re = 1'b1; ore = 1'b1; ra = k[7:0];
      step();
      if (k >= 1) check($sformatf("stream_pd%h_%0d", pwr, k), {21'd0, dout}, 32'((k - 1) & 255));
    end
    idle_inputs();
  endtask

  initial begin
    total = 0; bad = 0; gcnt = 0;
    nvdla_core_rstn = 1'b0;
    pwrbus_ram_pd = '0;
    idle_inputs();
    step(); step();
    check("reset_dout", {21'd0, dout}, 32'h000);
    nvdla_core_rstn = 1'b1;
    step();

    // Basic read
    we = 1'b1; wa = 8'h00; di = 11'h7FF; step();
    wa = 8'hFF; di = 11'h123; step();
    we = 1'b0; re = 1'b1; ra = 8'hFF; step();
    check("basic_before_ore", {21'd0, dout}, 32'h000);
    re = 1'b0; ore = 1'b1; step();
    check("basic_read", {21'd0, dout}, 32'h123);

    // Stall on ore
    ore = 1'b0; re = 1'b1; ra = 8'h00; step();
    check("stall_load", {21'd0, dout}, 32'h123);
    re = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      check($sformatf("stall_hold_%0d", s), {21'd0, dout}, 32'h123);
    end
    ore = 1'b1; step();
    check("stall_release", {21'd0, dout}, 32'h7FF);
    step();
    check("ore_repeat", {21'd0, dout}, 32'h7FF);
    ore = 1'b0;

    // Mid-run reset keeps the array
    we = 1'b1; wa = 8'h10; di = 11'h5A5; step();
    we = 1'b0;
    nvdla_core_rstn = 1'b0;
    #1;
    check("async_reset_dout", {21'd0, dout}, 32'h000);
    we = 1'b1; wa = 8'h10; di = 11'h001; re = 1'b1; ra = 8'h00; ore = 1'b1;
    step(); step();
    check("reset_held_dout", {21'd0, dout}, 32'h000);
    idle_inputs();
    nvdla_core_rstn = 1'b1;
    ore = 1'b1; step();
    check("post_reset_rd_data", {21'd0, dout}, 32'h000);
    ore = 1'b0; re = 1'b1; ra = 8'h10; step();
    re = 1'b0; ore = 1'b1; step();
    check("array_retained", {21'd0, dout}, 32'h5A5);
    idle_inputs();

    // Pipelined stream across power-bus settings
    stream(32'hFFFF_FFFF);
    stream(32'h0000_0000);

    // Same-address contention returns old data
    we = 1'b1; wa = 8'h20; di = 11'h0AA; step();
    di = 11'h155; re = 1'b1; ra = 8'h20; step();
    we = 1'b0; re = 1'b0; ore = 1'b1; step();
    check("contention_old", {21'd0, dout}, 32'h0AA);
    ore = 1'b0; re = 1'b1; ra = 8'h20; step();
    re = 1'b0; ore = 1'b1; step();
    check("contention_new", {21'd0, dout}, 32'h155);

    // Idle: no gated edges, dout stable
    idle_inputs();
    step();
    gcnt = 0;
    for (int s = 0; s < 10; s++) step();
    check("idle_no_edges", gcnt, 32'd0);
    check("idle_dout", {21'd0, dout}, 32'h155);
    ore = 1'b1; step();
    check("gated_edge_resume", gcnt, 32'd1);
    ore = 1'b0; step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
